// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between the decoder/response mux and one memory responder.
// The master modport is the interconnect side: it drives the address phase and the global HREADY.
interface ahb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ahb_sel_in;
  logic [ADDR_WIDTH-1:0] ahb_addr_in;
  logic [1:0]            ahb_trans_in;
  logic                  ahb_write_in;
  logic [2:0]            ahb_size_in;
  logic [DATA_WIDTH-1:0] ahb_wdata_in;
  logic                  ahb_ready_in;
  logic                  ahb_ready_out;
  logic                  ahb_resp_out;
  logic [DATA_WIDTH-1:0] ahb_rdata_out;

  modport master (
    output ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in, ahb_size_in,
           ahb_wdata_in, ahb_ready_in,
    input  ahb_ready_out, ahb_resp_out, ahb_rdata_out
  );

  modport slave (
    input  ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in, ahb_size_in,
           ahb_wdata_in, ahb_ready_in,
    output ahb_ready_out, ahb_resp_out, ahb_rdata_out
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-addressed register memory, with fixed wait
// states, little-endian byte-lane writes and a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int WAIT_STATES    = 0
) (
  input logic            ahb_clk_in,
  input logic            ahb_rstn_in,
  ahb_slave_mem_if.slave bus
);

  localparam int          IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);
  localparam int          LANES   = AHB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                    state_q;
  logic [3:0]                wcnt_q;
  logic                      ready_q;
  logic                      resp_q;
  logic                      dphase_q;
  logic                      write_q;
  logic [IDX_W-1:0]          idx_q;
  logic [LANES-1:0]          lanes_q;
  logic [AHB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                      accept;
  logic                      bad_size;
  logic                      misaligned;
  logic                      out_of_range;
  logic                      acc_err;
  logic [LANES-1:0]          acc_lanes;
  logic [13:0]               word_off;
  logic                      complete;

  // Address-phase decode; the range check deliberately looks at addr[15:0] only.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accept       = bus.ahb_sel_in && bus.ahb_ready_in &&
                   (bus.ahb_trans_in inside {2'b10, 2'b11});
    word_off     = bus.ahb_addr_in[15:2];
    bad_size     = bus.ahb_size_in > 3'd2;
    misaligned   = ((bus.ahb_size_in == 3'd1) && bus.ahb_addr_in[0]) ||
                   ((bus.ahb_size_in == 3'd2) && (bus.ahb_addr_in[1:0] != 2'b00));
    out_of_range = 32'(word_off) >= DEPTH_W;
    acc_err      = bad_size || misaligned || out_of_range;
    acc_lanes    = '1;
    case (bus.ahb_size_in)
      3'd0:    acc_lanes = 4'b0001 << bus.ahb_addr_in[1:0];
      3'd1:    acc_lanes = bus.ahb_addr_in[1] ? 4'b1100 : 4'b0011;
      default: acc_lanes = '1;
    endcase
  end

  // Response FSM; ready/resp are registered alongside the state they belong to.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      ready_q  <= 1'b1;
      resp_q   <= 1'b0;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      lanes_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ERR2: begin
          dphase_q <= 1'b0;
          state_q  <= ST_IDLE;
          ready_q  <= 1'b1;
          resp_q   <= 1'b0;
          if (accept) begin
            idx_q   <= bus.ahb_addr_in[2 +: IDX_W];
            write_q <= bus.ahb_write_in;
            lanes_q <= acc_lanes;
            if (acc_err) begin
              state_q <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              dphase_q <= 1'b1;
              state_q  <= ST_WAIT;
              wcnt_q   <= WS_LOAD;
              ready_q  <= 1'b0;
            end else begin
              dphase_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt_q == 4'd1) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            ready_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  // The completing data phase is the first IDLE cycle with an OKAY transfer outstanding.
  assign complete = dphase_q && (state_q == ST_IDLE);

  // NOTE: the memory is reset word by word because a cleared memory is part of the reset contract.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (complete && write_q) begin
      for (int b = 0; b < LANES; b++) begin
        if (lanes_q[b]) mem_q[idx_q][8*b +: 8] <= bus.ahb_wdata_in[8*b +: 8];
      end
    end
  end

  assign bus.ahb_ready_out = ready_q;
  assign bus.ahb_resp_out  = resp_q;
  assign bus.ahb_rdata_out = (complete && !write_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench: three responders (0, 2 and 3 wait states) on shared stimulus,
// compared against a transaction-level memory model built from the AHB rules.
module tb_ahb_slave_mem;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic        write;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic        stall;
  logic [1:0]  active;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [3][DEPTH];

  logic        rdy_v [3];
  logic        rsp_v [3];
  logic [31:0] rd_v  [3];
  logic        obs_ready;
  logic        obs_resp;
  logic [31:0] obs_rdata;

  always #5 clk = ~clk;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].ahb_sel_in   = sel && (active == g);
    assign bus[g].ahb_addr_in  = addr;
    assign bus[g].ahb_trans_in = trans;
    assign bus[g].ahb_write_in = write;
    assign bus[g].ahb_size_in  = size;
    assign bus[g].ahb_wdata_in = wdata;
    assign bus[g].ahb_ready_in = bus[g].ahb_ready_out && !stall;
    assign rdy_v[g]            = bus[g].ahb_ready_out;
    assign rsp_v[g]            = bus[g].ahb_resp_out;
    assign rd_v[g]             = bus[g].ahb_rdata_out;

    ahb_slave_mem #(
      .AHB_ADDR_WIDTH(32),
      .AHB_DATA_WIDTH(32),
      .MEM_DEPTH     (DEPTH),
      .WAIT_STATES   (ws_of(g))
    ) u_dut (
      .ahb_clk_in (clk),
      .ahb_rstn_in(rstn),
      .bus        (bus[g])
    );
  end

  assign obs_ready = rdy_v[active];
  assign obs_resp  = rsp_v[active];
  assign obs_rdata = rd_v[active];

  // ---------------- reference model ----------------
  function automatic bit is_err(input logic [2:0] sz, input logic [31:0] a);
    int unsigned word;
    word = 32'(a[15:2]);
    if (sz > 3'd2) return 1'b1;
    if (sz == 3'd1 && a[0]) return 1'b1;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return word >= DEPTH;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [2:0] sz, input logic [1:0] off);
    logic [31:0] r;
    bit hit;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      hit = (sz == 3'd2) || (sz == 3'd1 && (b / 2) == int'(off[1])) ||
            (sz == 3'd0 && b == int'(off));
      if (hit) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DEPTH; i++) model_mem[k][i] = 32'h0;
  endtask

  task automatic drive_ap(input bit s, input logic [1:0] t, input bit w,
                          input logic [2:0] sz, input logic [31:0] a);
    sel = s; trans = t; write = w; size = sz; addr = a;
  endtask

  // One isolated transfer on the active responder, checked cycle by cycle.
  task automatic run_xfer(input string tag, input bit s, input logic [1:0] t, input bit w,
                          input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
    logic [33:0] expq [$];
    logic [33:0] got;
    bit acc, err;
    int idx;
    acc = s && t[1];
    err = acc && is_err(sz, a);
    idx = int'(a[15:2]);
    if (!acc) expq.push_back({1'b1, 1'b0, 32'h0});
    else if (err) begin
      expq.push_back({1'b0, 1'b1, 32'h0});
      expq.push_back({1'b1, 1'b1, 32'h0});
    end else begin
      for (int i = 0; i < ws_of(int'(active)); i++) expq.push_back({1'b0, 1'b0, 32'h0});
      expq.push_back({1'b1, 1'b0, w ? 32'h0 : model_mem[active][idx]});
    end
    @(negedge clk);
    drive_ap(s, t, w, sz, a);
    @(negedge clk);
    drive_ap(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    wdata = wd;
    for (int i = 0; i < expq.size(); i++) begin
      if (i > 0) @(negedge clk);
      got = {obs_ready, obs_resp, obs_rdata};
      vectors++;
      if (got !== expq[i]) begin
        $display("FAIL %s cycle %0d: got rdy=%0b resp=%0b rdata=%h, want rdy=%0b resp=%0b rdata=%h",
                 tag, i + 1, got[33], got[32], got[31:0], expq[i][33], expq[i][32], expq[i][31:0]);
        miscompares++;
      end
    end
    rd = obs_rdata;
    if (acc && !err && w) model_mem[active][idx] = merge(model_mem[active][idx], wd, sz, a[1:0]);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    clear_model();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      active = 2'(k);
      #1;
      vectors++;
      if ({obs_ready, obs_resp, obs_rdata} !== {1'b1, 1'b0, 32'h0}) begin
        $display("FAIL reset_state dut%0d: got %0b/%0b/%h want 1/0/0", k, obs_ready, obs_resp, obs_rdata);
        miscompares++;
      end
    end
    rstn = 1'b1;
    active = 2'd1;
    run_xfer("rst_prefill", 1'b1, 2'b10, 1'b1, 3'd2, 32'h0, 32'h11223344, rd);
    @(negedge clk);
    drive_ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    drive_ap(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    vectors++;
    if (obs_ready !== 1'b0) begin
      $display("FAIL rst_in_wait: got rdy=%0b want 0", obs_ready);
      miscompares++;
    end
    rstn = 1'b0;
    clear_model();
    #1;
    vectors++;
    if ({obs_ready, obs_resp, obs_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      $display("FAIL rst_async: got %0b/%0b/%h want 1/0/0", obs_ready, obs_resp, obs_rdata);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({obs_ready, obs_resp, obs_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      $display("FAIL rst_next: got %0b/%0b/%h want 1/0/0", obs_ready, obs_resp, obs_rdata);
      miscompares++;
    end
    rstn = 1'b1;
    run_xfer("rst_read0", 1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0, rd);
    vectors++;
    if (rd !== 32'h0) begin
      $display("FAIL rst_word0: got %h want 00000000", rd);
      miscompares++;
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd;
    active = 2'd0;
    run_xfer("byte_wr", 1'b1, 2'b10, 1'b1, 3'd0, 32'h00000011, 32'h5555AA55, rd);
    run_xfer("byte_rd", 1'b1, 2'b10, 1'b0, 3'd2, 32'h00000010, 32'h0, rd);
    vectors++;
    if (rd !== 32'h0000AA00) begin
      $display("FAIL byte_lane: got %h want 0000aa00", rd);
      miscompares++;
    end
    run_xfer("half_wr", 1'b1, 2'b10, 1'b1, 3'd1, 32'h00000012, 32'h12347777, rd);
    run_xfer("half_rd", 1'b1, 2'b10, 1'b0, 3'd0, 32'h00000013, 32'h0, rd);
    vectors++;
    if (rd !== 32'h1234AA00) begin
      $display("FAIL half_lane: got %h want 1234aa00", rd);
      miscompares++;
    end
  endtask

  task automatic test_round_trip();
    logic [33:0] want [3];
    active = 2'd0;
    want[0] = {1'b1, 1'b0, 32'h0};
    want[1] = {1'b1, 1'b0, 32'h0};
    want[2] = {1'b1, 1'b0, 32'hDEADBEEF};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) drive_ap(1'b1, 2'b10, 1'b1, 3'd2, 32'h20300010);
      else if (c == 1) begin
        drive_ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h20300010);
        wdata = 32'hDEADBEEF;
      end else drive_ap(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
      vectors++;
      if ({obs_ready, obs_resp, obs_rdata} !== want[c]) begin
        $display("FAIL round_trip c%0d: got %0b/%0b/%h want %0b/%0b/%h", c, obs_ready, obs_resp,
                 obs_rdata, want[c][33], want[c][32], want[c][31:0]);
        miscompares++;
      end
    end
    model_mem[0][4] = 32'hDEADBEEF;
  endtask

  task automatic test_wait();
    logic [31:0] rd;
    logic [33:0] want;
    active = 2'd2;
    run_xfer("wait_pre5", 1'b1, 2'b10, 1'b1, 3'd2, 32'h14, 32'hA5A50005, rd);
    run_xfer("wait_pre6", 1'b1, 2'b10, 1'b1, 3'd2, 32'h18, 32'h5A5A0006, rd);
    @(negedge clk);
    drive_ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h14);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 4) drive_ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h18);
      else drive_ap(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
      want = {(c == 4 || c == 8), 1'b0,
              (c == 4) ? 32'hA5A50005 : ((c == 8) ? 32'h5A5A0006 : 32'h0)};
      vectors++;
      if ({obs_ready, obs_resp, obs_rdata} !== want) begin
        $display("FAIL wait_held c%0d: got %0b/%0b/%h want %0b/%0b/%h", c, obs_ready, obs_resp,
                 obs_rdata, want[33], want[32], want[31:0]);
        miscompares++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    active = 2'd0;
    run_xfer("stall_pre", 1'b1, 2'b10, 1'b1, 3'd2, 32'h1C, 32'h77770007, rd);
    stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h1C);
      if (c == 3) stall = 1'b0;
      vectors++;
      if ({obs_ready, obs_resp, obs_rdata} !== {1'b1, 1'b0, 32'h0}) begin
        $display("FAIL stall_hold c%0d: got %0b/%0b/%h want 1/0/0", c, obs_ready, obs_resp, obs_rdata);
        miscompares++;
      end
    end
    @(negedge clk);
    drive_ap(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    vectors++;
    if ({obs_ready, obs_resp, obs_rdata} !== {1'b1, 1'b0, 32'h77770007}) begin
      $display("FAIL stall_release: got %0b/%0b/%h want 1/0/77770007", obs_ready, obs_resp, obs_rdata);
      miscompares++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    active = 2'd0;
    run_xfer("err_half_odd", 1'b1, 2'b10, 1'b1, 3'd1, 32'h00000001, 32'hFFFFFFFF, rd);
    run_xfer("err_oor", 1'b1, 2'b10, 1'b1, 3'd2, 32'h00000400, 32'hFFFFFFFF, rd);
    run_xfer("err_size3", 1'b1, 2'b10, 1'b1, 3'd3, 32'h00000008, 32'hFFFFFFFF, rd);
    run_xfer("err_rd_size3", 1'b1, 2'b10, 1'b0, 3'd3, 32'h00000010, 32'h0, rd);
    run_xfer("err_chk_w0", 1'b1, 2'b10, 1'b0, 3'd2, 32'h00000000, 32'h0, rd);
    run_xfer("err_chk_w2", 1'b1, 2'b10, 1'b0, 3'd2, 32'h00000008, 32'h0, rd);
  endtask

  task automatic test_idle_desel();
    logic [31:0] rd;
    active = 2'd0;
    run_xfer("idle_sel", 1'b1, 2'b00, 1'b1, 3'd2, 32'h20, 32'hCAFE0001, rd);
    run_xfer("desel", 1'b0, 2'b10, 1'b1, 3'd2, 32'h20, 32'hCAFE0002, rd);
    run_xfer("busy", 1'b1, 2'b01, 1'b1, 3'd2, 32'h20, 32'hCAFE0003, rd);
    run_xfer("idle_chk", 1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0, rd);
  endtask

  typedef struct {
    bit          valid;
    bit          w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } xfer_t;

  // Zero-wait pipelined traffic: one address phase every cycle, read-after-write included.
  task automatic test_back_to_back();
    xfer_t pend, nxt;
    logic [33:0] want;
    int idx;
    logic [1:0] off;
    active = 2'd0;
    pend = '{valid: 1'b0, w: 1'b0, sz: 3'd0, a: 32'h0, wd: 32'h0};
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      idx = int'(pend.a[15:2]);
      want = {1'b1, 1'b0, (pend.valid && !pend.w) ? model_mem[0][idx] : 32'h0};
      vectors++;
      if ({obs_ready, obs_resp, obs_rdata} !== want) begin
        $display("FAIL b2b #%0d: got %0b/%0b/%h want %0b/%0b/%h", i, obs_ready, obs_resp, obs_rdata,
                 want[33], want[32], want[31:0]);
        miscompares++;
      end
      if (pend.valid && pend.w)
        model_mem[0][idx] = merge(model_mem[0][idx], pend.wd, pend.sz, pend.a[1:0]);
      wdata = pend.valid ? pend.wd : 32'h0;
      nxt.valid = (i < 40);
      nxt.w     = 1'($urandom_range(0, 1));
      nxt.sz    = 3'($urandom_range(0, 2));
      off       = 2'($urandom_range(0, 3));
      if (nxt.sz == 3'd1) off[0] = 1'b0;
      if (nxt.sz == 3'd2) off = 2'b00;
      nxt.a     = $urandom();
      nxt.a[15:0] = 16'($urandom_range(0, 7) * 4) | 16'(off);
      nxt.wd    = $urandom();
      if (nxt.valid) drive_ap(1'b1, 2'b10, nxt.w, nxt.sz, nxt.a);
      else drive_ap(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
      pend = nxt;
    end
  endtask

  // Mixed legal, illegal and ignored transfers across all three wait-state settings.
  task automatic test_random();
    logic [31:0] rd, a;
    logic [2:0] sz;
    logic [1:0] t;
    bit s;
    int kind;
    for (int i = 0; i < 45; i++) begin
      active = 2'($urandom_range(0, 2));
      kind   = $urandom_range(0, 9);
      s      = (kind != 2);
      t      = (kind == 0) ? 2'b00 : ((kind == 1) ? 2'b01 : 2'($urandom_range(2, 3)));
      sz     = (kind == 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a      = $urandom();
      if (kind == 5) a[15:0] = 16'(DEPTH * 4 + $urandom_range(0, 500) * 4);
      else a[15:0] = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      run_xfer("random", s, t, 1'($urandom_range(0, 1)), sz, a, $urandom(), rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; sel = 1'b0; trans = 2'b00; write = 1'b0; size = 3'd0;
    addr = 32'h0; wdata = 32'h0; stall = 1'b0; active = 2'd0;
    test_reset();
    test_lanes();
    test_round_trip();
    test_wait();
    test_stall();
    test_errors();
    test_idle_desel();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite responder that terminates transfers selected by the AHB decoder and services them from an internal word-addressed register memory. It has configurable wait states, byte/halfword/word write strobing, and a two-cycle ERROR response for illegal accesses. It sits behind one `slave_sel_out` bit of the decoder. Its `ahb_ready_out`/`ahb_resp_out`/`ahb_rdata_out` feed the slave-to-master response multiplexer, which returns the global HREADY as `ahb_ready_in`.

## Interface
- AHB_ADDR_WIDTH, 32, address bus width
- AHB_DATA_WIDTH, 32, data bus width; fixed at 32
- MEM_DEPTH, 256, number of 32-bit words; power of two, at least 4
- WAIT_STATES, 0, data-phase wait cycles inserted on every OKAY transfer; 0..15

Ports:
- ahb_clk_in  in  1  clock, rising edge
- ahb_rstn_in  in  1  reset, asynchronous, active-low
- ahb_sel_in  in  1  slave select from decoder (HSELx)
- ahb_addr_in  in  AHB_ADDR_WIDTH  HADDR
- ahb_trans_in  in  2  HTRANS: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- ahb_write_in  in  1  HWRITE
- ahb_size_in  in  3  HSIZE
- ahb_wdata_in  in  32  HWDATA, valid in data phase
- ahb_ready_in  in  1  global HREADY from response mux
- ahb_ready_out  out  1  HREADYOUT
- ahb_resp_out  out  1  HRESP: 0 OKAY, 1 ERROR
- ahb_rdata_out  out  32  HRDATA

## Operation
- **Address-phase accept:** `ahb_sel_in & ahb_ready_in & ahb_trans_in[1]` on a rising edge. On accept, register the address, write flag, size and an error flag.
- **IDLE/BUSY or unselected transfers:** not accepted; the slave gives a zero-wait OKAY response.
- **Error flag** is set if any of these hold:
  - `ahb_size_in` > 2;
  - the access is misaligned (halfword with addr[0]=1, word with addr[1:0]≠0);
  - the word index addr[AHB_ADDR_WIDTH-1:2] ≥ MEM_DEPTH, decoded relative to addr[15:0] only.
- **State machine:** IDLE, WAIT, ERR1, ERR2.
  - IDLE: outputs ready=1, resp=0.
    - Accept with error → ERR1.
    - Accept OKAY with WAIT_STATES>0 → WAIT, loading the wait counter with WAIT_STATES.
    - Accept OKAY with WAIT_STATES=0 → stay in IDLE; the next cycle is the completing data phase.
  - WAIT: ready=0, resp=0, counter decrements. At counter==1, go to the completing cycle (IDLE-equivalent, ready=1).
  - ERR1: ready=0, resp=1 → ERR2.
  - ERR2: ready=1, resp=1 → IDLE. If this cycle also accepts a new transfer, process that transfer normally.
- **Completing data-phase cycle:** the cycle with ready_out=1 after an accepted OKAY transfer.
  - Writes: update the memory word at the rising edge ending this cycle. Lanes are little-endian:
    - byte: lane addr[1:0];
    - halfword: lanes {addr[1],0} and {addr[1],1};
    - word: all four lanes.
    - Unwritten lanes are unchanged.
  - Reads: `ahb_rdata_out` = full 32-bit word at the registered index, for any size.
- **`ahb_rdata_out` outside a read completing cycle:** 0.
- **Errored transfers** never modify memory and drive rdata=0.
- **Pipelining:**
  - A new address phase can be accepted in the same cycle as the previous transfer's completing data phase.
  - Back-to-back zero-wait transfers proceed one per cycle.
  - Read-after-write to the same word returns the newly written value.
- **Reset** (asserted at any time, including mid-wait or mid-error):
  - state → IDLE, wait counter → 0;
  - ahb_ready_out=1, ahb_resp_out=0, ahb_rdata_out=0;
  - all memory words → 0;
  - any pending transfer is discarded.

## Timing
- **OKAY latency:** address phase at cycle N; data phase completes at cycle N+1+WAIT_STATES with ready_out=1.
- **ready_out low:** cycles N+1 .. N+WAIT_STATES.
- **ERROR:** cycle N+1 has ready=0/resp=1, cycle N+2 has ready=1/resp=1. This holds regardless of WAIT_STATES.
- **Outputs:**
  - ready_out and resp_out are registered, driven from state only.
  - rdata_out is combinational from the registered index and memory.
- **Held address phase:** while `ahb_ready_in`=0 because another slave is stalling, this slave accepts nothing and holds its state.
- **Deselection:** transfers accepted before deselection still complete. ahb_sel_in is sampled only at accept.

## Test plan
- **Reset values:** assert reset mid-transfer with WAIT_STATES=2 → ready_out=1, resp_out=0, rdata_out=0 next cycle. A subsequent read of word 0 returns 0x00000000.
- **Zero-wait round trip:** word write 0xDEADBEEF to 0x20300010, then back-to-back read of 0x20300010 → ready_out stays 1 throughout, rdata=0xDEADBEEF one cycle after the read address phase.
- **Byte and halfword lanes:**
  - byte write 0xAA to 0x...011 over word 0x00000000 → read 0x0000AA00;
  - then halfword write 0x1234 to 0x...012 → read 0x1234AA00.
- **Wait states (WAIT_STATES=3):** read → ready_out=0 for exactly 3 cycles, then 1 with valid data. A NONSEQ held during the stall is accepted only at the ready cycle.
- **Errors:** halfword at 0x...001, word at index MEM_DEPTH, and HSIZE=3 each give ready=0/resp=1 then ready=1/resp=1, with no memory change (verify by read-back).
- **IDLE/BUSY and deselected:** HTRANS=IDLE with sel=1, and NONSEQ with sel=0 → ready_out=1, resp_out=0, no memory write.
